// File: rtl/fir_serial_mac.sv
`default_nettype none
// ============================================================================
// Module      : fir_serial_mac
// Description : Time-multiplexed FIR core with one signed MAC over a circular
//               delay line, runtime-writable coefficients, round and saturate.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_serial_mac #(
    parameter int TAPS  = 16,
    parameter int DW    = 24,
    parameter int CW    = 16,
    parameter int OW    = 24,
    parameter int SHIFT = 15
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [DW-1:0]            i_sample,
    input  logic                     i_coef_we,
    input  logic [$clog2(TAPS)-1:0]  i_coef_addr,
    input  logic [CW-1:0]            i_coef_data,
    output logic                     o_valid,
    output logic [OW-1:0]            o_result,
    output logic                     o_sat,
    output logic                     o_busy
);

    localparam int c_IW = $clog2(TAPS);
    localparam int c_PW = DW + CW;
    localparam int c_AW = DW + CW + c_IW;
    localparam int c_RW = c_AW + 1;

    localparam logic [c_IW-1:0]        c_LAST   = c_IW'(TAPS - 1);
    localparam logic [c_IW-1:0]        c_TAPS_M = c_IW'(TAPS);
    localparam logic signed [c_RW-1:0] c_HALF   = c_RW'(1) << (SHIFT - 1);
    localparam logic signed [c_RW-1:0] c_MAX    = {{(c_RW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [c_RW-1:0] c_MIN    = {{(c_RW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                   r_state;
    logic signed [DW-1:0]     r_x [TAPS];
    logic signed [CW-1:0]     r_c [TAPS];
    logic [c_IW-1:0]          r_wptr;
    logic [c_IW-1:0]          r_base;
    logic [c_IW-1:0]          r_k;
    logic signed [c_AW-1:0]   r_acc;
    logic                     r_ready;
    logic                     r_busy;
    logic                     r_valid;
    logic                     r_sat;
    logic [OW-1:0]            r_result;

    logic [c_IW-1:0]          w_idx;
    logic signed [c_PW-1:0]   w_prod;
    logic signed [c_AW-1:0]   w_sum;
    logic signed [c_RW-1:0]   w_rnd;
    logic signed [c_RW-1:0]   w_shr;
    logic [OW-1:0]            w_res;
    logic                     w_clip;

    // (base - k) mod TAPS: the true value is below TAPS, so c_IW-bit wrap is exact.
    always_comb begin
        w_idx = r_base - r_k;
        if (r_base < r_k) begin
            w_idx = r_base - r_k + c_TAPS_M;
        end
        w_prod = r_x[w_idx] * r_c[r_k];
        w_sum  = r_acc + {{(c_AW-c_PW){w_prod[c_PW-1]}}, w_prod};
    end

    always_comb begin
        w_rnd  = $signed({r_acc[c_AW-1], r_acc}) + c_HALF;
        w_shr  = w_rnd >>> SHIFT;
        w_clip = 1'b0;
        w_res  = w_shr[OW-1:0];
        if (w_shr > c_MAX) begin
            w_clip = 1'b1;
            w_res  = c_MAX[OW-1:0];
        end else if (w_shr < c_MIN) begin
            w_clip = 1'b1;
            w_res  = c_MIN[OW-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            for (int i = 0; i < TAPS; i++) begin
                r_x[i] <= '0;
                r_c[i] <= '0;
            end
            r_wptr   <= '0;
            r_base   <= '0;
            r_k      <= '0;
            r_acc    <= '0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_sat    <= 1'b0;
            r_result <= '0;
        end else if (i_flush) begin
            // Coefficients and the last result survive a flush.
            r_state <= S_IDLE;
            for (int i = 0; i < TAPS; i++) begin
                r_x[i] <= '0;
            end
            r_wptr  <= '0;
            r_k     <= '0;
            r_acc   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (i_coef_we && !r_busy && (32'(i_coef_addr) < TAPS)) begin
                r_c[i_coef_addr] <= i_coef_data;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_x[r_wptr] <= i_sample;
                        r_base      <= r_wptr;
                        r_wptr      <= (r_wptr == c_LAST) ? '0 : r_wptr + 1'b1;
                        r_acc       <= '0;
                        r_k         <= '0;
                        r_ready     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc <= w_sum;
                    if (r_k == c_LAST) begin
                        r_state <= S_OUT;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_OUT: begin
                    r_result <= w_res;
                    r_sat    <= w_clip;
                    r_valid  <= 1'b1;
                    r_ready  <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready  = r_ready;
    assign o_busy   = r_busy;
    assign o_valid  = r_valid;
    assign o_sat    = r_sat;
    assign o_result = r_result;

endmodule
`default_nettype wire
